// File: rtl/ps2_key_sequencer.sv
// PS/2 Set-2 key sequencer: drains the keyboard FIFO and tracks the pressed, held and released state of keys.
// Optional feature: define PS2_TYPEMATIC_EN so that typematic repeats also raise event_pulse.
module ps2_key_sequencer #(
    parameter int          COUNT_W    = 8,
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    input  logic               clr_ovf,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_valid,
    output logic [COUNT_W-1:0] key_count,
    output logic               event_pulse,
    output logic               ovf_sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [7:0]         byte_q,       byte_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic [7:0]         key_code_q,   key_code_d;
    logic               key_ext_q,    key_ext_d;
    logic               key_valid_q,  key_valid_d;
    logic [COUNT_W-1:0] key_count_q,  key_count_d;
    logic               event_q,      event_d;
    logic               ovf_q,        ovf_d;
    logic               brk_pend_q,   brk_pend_d;
    logic               ext_pend_q,   ext_pend_d;

    // True when the decoded byte refers to the key that is currently held
    function automatic logic held_match(input logic [7:0] code_in, input logic ext_in,
                                        input logic [7:0] held_code, input logic held_ext,
                                        input logic held_valid);
        held_match = held_valid && (code_in == held_code) && (ext_in == held_ext);
    endfunction

    // Handshake FSM, scan-code decode and overflow bookkeeping
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = nextdata_n_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_valid_d  = key_valid_q;
        key_count_d  = key_count_q;
        event_d      = event_q;
        ovf_d        = ovf_q;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end else begin
                    state_d      = S_IDLE;
                end
            end
            S_POP: begin
                nextdata_n_d = 1'b1;
                state_d      = S_WAIT;
                if (byte_q == EXT_CODE) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == BREAK_CODE) begin
                    brk_pend_d = 1'b1;
                end else if (brk_pend_q) begin
                    // A break for any key other than the held one is dropped
                    if (held_match(byte_q, ext_pend_q, key_code_q, key_ext_q, key_valid_q)) begin
                        key_valid_d = 1'b0;
                    end else begin
                        key_valid_d = key_valid_q;
                    end
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else if (held_match(byte_q, ext_pend_q, key_code_q, key_ext_q, key_valid_q)) begin
`ifdef PS2_TYPEMATIC_EN
                    event_d    = 1'b1;
`else
                    event_d    = 1'b0;
`endif
                    ext_pend_d = 1'b0;
                end else begin
                    key_code_d  = byte_q;
                    key_ext_d   = ext_pend_q;
                    key_valid_d = 1'b1;
                    key_count_d = key_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    event_d     = 1'b1;
                    ext_pend_d  = 1'b0;
                end
            end
            S_WAIT: begin
                event_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                nextdata_n_d = 1'b1;
                event_d      = 1'b0;
                state_d      = S_IDLE;
            end
        endcase

        // Overflow corrupts the prefix context; it overrides whatever the decode computed
        if (overflow) begin
            ovf_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end else if (clr_ovf) begin
            ovf_d      = 1'b0;
        end else begin
            ovf_d      = ovf_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_valid_q  <= 1'b0;
            key_count_q  <= {COUNT_W{1'b0}};
            event_q      <= 1'b0;
            ovf_q        <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_valid_q  <= key_valid_d;
            key_count_q  <= key_count_d;
            event_q      <= event_d;
            ovf_q        <= ovf_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_valid   = key_valid_q;
    assign key_count   = key_count_q;
    assign event_pulse = event_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Randomized bench for ps2_key_sequencer: a queue stands in for the keyboard FIFO and a
// byte-level model of the Set-2 press/release rules predicts every output.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic [7:0] key_count;
    logic       event_pulse;
    logic       ovf_sticky;

    ps2_key_sequencer #(.COUNT_W(8), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
        .clk(clk), .rst(rst), .ready(ready), .data(data), .overflow(overflow),
        .clr_ovf(clr_ovf), .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
        .key_valid(key_valid), .key_count(key_count), .event_pulse(event_pulse),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fifo[$];
    int  ev_seen  = 0;
    int  n_lows   = 0;
    int  n_pushed = 0;
    bit  chk_pending = 1'b0;

    logic [7:0] m_code;
    bit  m_ext, m_valid, m_brk, m_extp, m_ovf, m_ev;
    int  m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_code = 8'h00; m_ext = 0; m_valid = 0; m_brk = 0; m_extp = 0;
        m_ovf = 0; m_ev = 0; m_cnt = 0;
    endfunction

    // Press/release interpretation of one popped byte
    function automatic void model_byte(input logic [7:0] b);
        bit same;
        same = m_valid && (b == m_code) && (m_extp == m_ext);
        m_ev = 0;
        if (b == 8'hE0) m_extp = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (same) m_valid = 0;
            m_brk = 0; m_extp = 0;
        end else if (same) begin
`ifdef PS2_TYPEMATIC_EN
            m_ev = 1;
`endif
            m_extp = 0;
        end else begin
            m_code = b; m_ext = m_extp; m_valid = 1;
            m_cnt = (m_cnt + 1) % 256; m_ev = 1; m_extp = 0;
        end
    endfunction

    task automatic step();
        logic [7:0] b;
        @(negedge clk);
        if (event_pulse) ev_seen++;
        if (chk_pending) begin
            check_eq("lat_code",  key_code,    m_code);
            check_eq("lat_ext",   key_ext,     m_ext);
            check_eq("lat_valid", key_valid,   m_valid);
            check_eq("lat_count", key_count,   m_cnt);
            check_eq("lat_event", event_pulse, m_ev);
            check_eq("lat_ndn",   nextdata_n,  1'b1);
            chk_pending = 0;
        end
        if (!nextdata_n) begin
            n_lows++;
            if (fifo.size() == 0) begin
                check_eq("pop_empty", 32'd1, 32'd0);
            end else begin
                b = fifo.pop_front();
                model_byte(b);
                chk_pending = 1;
            end
        end
        ready = (fifo.size() != 0);
        data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        n_pushed++;
    endtask

    task automatic drain_and_check(input string tag);
        int budget = 0;
        while ((fifo.size() != 0 || chk_pending) && budget < 400) begin
            step();
            budget++;
        end
        repeat (3) step();
        check_eq({tag, "_drain"}, (budget < 400), 1'b1);
        check_eq({tag, "_code"},  key_code,   m_code);
        check_eq({tag, "_ext"},   key_ext,    m_ext);
        check_eq({tag, "_valid"}, key_valid,  m_valid);
        check_eq({tag, "_count"}, key_count,  m_cnt);
        check_eq({tag, "_ovf"},   ovf_sticky, m_ovf);
        check_eq({tag, "_lows"},  n_lows,     n_pushed);
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b0; overflow = 1'b0; clr_ovf = 1'b0;
        fifo.delete(); chk_pending = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_lows = 0; n_pushed = 0;
    endtask

    // Drive overflow/clr_ovf for one cycle while the sequencer is idle
    task automatic pulse_ovf(input bit ov, input bit clr);
        overflow = ov; clr_ovf = clr;
        if (ov) begin m_ovf = 1; m_brk = 0; m_extp = 0; end
        else if (clr) m_ovf = 0;
        step();
        overflow = 1'b0; clr_ovf = 1'b0;
        step();
    endtask

    int ev0;
    logic [7:0] rb;
    int pick;

    initial begin
        model_reset();
        do_reset();
        step();
        check_eq("rst_ndn",   nextdata_n,  1'b1);
        check_eq("rst_code",  key_code,    8'h00);
        check_eq("rst_valid", key_valid,   1'b0);
        check_eq("rst_count", key_count,   8'h00);
        check_eq("rst_event", event_pulse, 1'b0);
        check_eq("rst_ovf",   ovf_sticky,  1'b0);

        ev0 = ev_seen;
        push(8'h1C); drain_and_check("press_a");
        check_eq("press_a_code_k", key_code, 8'h1C);
        check_eq("press_a_cnt_k",  key_count, 8'd1);
        check_eq("press_a_ev",     ev_seen - ev0, 1);

        ev0 = ev_seen;
        push(8'hF0); push(8'h1C); drain_and_check("rel_a");
        check_eq("rel_a_valid_k", key_valid, 1'b0);
        check_eq("rel_a_ev",      ev_seen - ev0, 0);

        push(8'hE0); push(8'h74); drain_and_check("ext_make");
        check_eq("ext_make_ext_k", key_ext, 1'b1);
        push(8'hE0); push(8'hF0); push(8'h74); drain_and_check("ext_brk");
        check_eq("ext_brk_valid_k", key_valid, 1'b0);

        ev0 = ev_seen;
        push(8'h1C); push(8'h1C); push(8'h1C); drain_and_check("typematic");
`ifdef PS2_TYPEMATIC_EN
        check_eq("typematic_ev", ev_seen - ev0, 3);
`else
        check_eq("typematic_ev", ev_seen - ev0, 1);
`endif

        pulse_ovf(1'b1, 1'b1);
        check_eq("ovf_win", ovf_sticky, 1'b1);
        pulse_ovf(1'b0, 1'b1);
        check_eq("ovf_clr", ovf_sticky, 1'b0);

        push(8'hF0); drain_and_check("brk_pre");
        pulse_ovf(1'b1, 1'b0);
        push(8'h1C); push(8'hF0); push(8'h2B); drain_and_check("ovf_flush");
        push(8'h1C); drain_and_check("ovf_make");

        // Random byte streams with prefixes, repeats and idle overflow pulses
        for (int blk = 0; blk < 40; blk++) begin
            for (int k = 0; k < 8; k++) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0, 1:    rb = 8'hE0;
                    2, 3:    rb = 8'hF0;
                    4, 5:    rb = 8'h1C;
                    6:       rb = 8'h74;
                    7:       rb = 8'h23;
                    default: begin
                        rb = 8'($urandom_range(1, 8'hDF));
                    end
                endcase
                push(rb);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 4)) step();
                end
            end
            drain_and_check("rand");
            if ($urandom_range(0, 4) == 0) pulse_ovf(1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) pulse_ovf(1'b0, 1'b1);
        end

        // Reset while the pop strobe is low
        push(8'h23);
        for (int t = 0; t < 20 && nextdata_n; t++) step();
        check_eq("mid_ndn_low", nextdata_n, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ndn",   nextdata_n,  1'b1);
        check_eq("mid_rst_code",  key_code,    8'h00);
        check_eq("mid_rst_valid", key_valid,   1'b0);
        check_eq("mid_rst_count", key_count,   8'h00);
        check_eq("mid_rst_event", event_pulse, 1'b0);
        do_reset();

        // 256 press/release pairs wrap the press counter back to zero
        for (int i = 0; i < 256; i++) begin
            rb = 8'(i % 200 + 1);
            if (i % 2 == 1) begin
                push(8'hE0); push(rb); push(8'hE0); push(8'hF0); push(rb);
            end else begin
                push(rb); push(8'hF0); push(rb);
            end
            if (i % 16 == 15) drain_and_check("wrap_blk");
        end
        check_eq("wrap_zero", key_count, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Controller that drains the ps2_keyboard receive FIFO through its ready / nextdata_n handshake.
- Decodes Set-2 scan-code framing (E0 extended prefix, F0 break prefix) into press/release state.
- Drives the key-display path with the last pressed key, a held flag, a press counter and a one-cycle press event.
- Sits between ps2_keyboard and the segment decoders in the keyboard top level.

Parameters:
- COUNT_W, 8, width of key_count (wraps modulo 2^COUNT_W).
- BREAK_CODE, 8'hF0, break-prefix byte.
- EXT_CODE, 8'hE0, extended-prefix byte.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ready  in  1  keyboard FIFO non-empty
- data  in  8  keyboard FIFO head byte, valid while ready=1
- overflow  in  1  keyboard FIFO overflow flag
- clr_ovf  in  1  clears ovf_sticky
- nextdata_n  out  1  active-low FIFO pop strobe
- key_code  out  8  scan code of last pressed key
- key_ext  out  1  last pressed key carried E0 prefix
- key_valid  out  1  a key is currently held
- key_count  out  COUNT_W  number of new presses
- event_pulse  out  1  one-cycle pulse per new press
- ovf_sticky  out  1  latched overflow

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; nextdata_n=1.
  - key_code=0, key_ext=0, key_valid=0, key_count=0, event_pulse=0, ovf_sticky=0.
  - Internal byte_q and prefix flags brk_pend/ext_pend cleared.
- FSM states IDLE, POP, WAIT:
  - IDLE: if ready=1 at edge N -> byte_q<=data, nextdata_n<=0, go POP; else stay.
  - POP: edge N+1 -> nextdata_n<=1, decode byte_q (below), go WAIT.
  - WAIT: edge N+2 -> event_pulse<=0, go IDLE. The guard cycle lets the FIFO read pointer settle before ready is resampled.
  - Result: nextdata_n low exactly one cycle per byte; max throughput one byte per 3 cycles; ready is ignored outside IDLE.
- Decode (registered at edge N+1):
  - byte_q==EXT_CODE -> ext_pend<=1; no other change.
  - byte_q==BREAK_CODE -> brk_pend<=1; no other change.
  - Other byte with brk_pend=1 -> release. If key_valid && byte_q==key_code && ext_pend==key_ext then key_valid<=0; otherwise ignored. Clear brk_pend and ext_pend.
  - Other byte with brk_pend=0 and key_valid && byte_q==key_code && ext_pend==key_ext -> typematic repeat: no count change, event per Optional Feature; clear ext_pend.
  - Other byte, make otherwise -> key_code<=byte_q, key_ext<=ext_pend, key_valid<=1, key_count<=key_count+1 (wraps all-ones -> 0), event_pulse<=1; clear ext_pend.
  - A press of a new key while another is held replaces it. Release of the old key is then ignored.
- Overflow handling:
  - ovf_sticky<=1 on any edge with overflow=1.
  - clr_ovf=1 clears ovf_sticky; simultaneous overflow=1 wins (stays 1).
  - On any edge with overflow=1, brk_pend and ext_pend clear because the stream is corrupt. If this coincides with a POP decode, the decode uses the pre-clear flags.
- Reset mid-operation: asserting rst in POP returns nextdata_n high immediately; the byte is discarded and the FSM restarts from IDLE.

Optional Feature:
- Macro PS2_TYPEMATIC_EN.
- Defined: a typematic repeat asserts event_pulse for one cycle; key_count is unchanged.
- Undefined: repeats produce no event_pulse; all other behaviour identical.

Test Plan:
- Press 'A': ready with data 8'h1C -> nextdata_n low 1 cycle; one edge later key_code=8'h1C, key_ext=0, key_valid=1, key_count=1, event_pulse high 1 cycle.
- Release 'A': bytes F0,1C -> two pops, key_valid=0, key_code stays 8'h1C, key_count=1, no event_pulse.
- Extended right-arrow: E0,74, then E0,F0,74 -> key_code=8'h74, key_ext=1, key_valid 1 then 0, key_count +1.
- Typematic: 1C,1C,1C -> key_count=1; event_pulse count is 3 with PS2_TYPEMATIC_EN, 1 without.
- Overflow: overflow=1 for one cycle with clr_ovf=1 -> ovf_sticky=1. Then clr_ovf=1 alone -> 0. Byte F0 followed by overflow, then 1C -> treated as make (key_valid=1).
- Wrap and reset: 256 distinct press/release pairs -> key_count returns to 0. rst asserted while nextdata_n=0 -> nextdata_n=1 and all outputs 0 immediately.
